fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  instruction-memory request valid.
REQ-005 imem_addr  output  32  request address (word-aligned).
REQ-006 imem_ready  input  1  memory accepts request this cycle.
REQ-007 imem_rvalid  input  1  read data valid.
REQ-008 imem_rdata  input  32  returned instruction word.
REQ-009 redirect_valid  input  1  taken branch/jal/jalr from execute; redirect the fetch stream.
REQ-010 redirect_pc  input  32  redirect target.
REQ-011 stall  input  1  decode/control stage cannot consume the held instruction.
REQ-012 inst_valid  output  1  inst/inst_pc hold a valid instruction.
REQ-013 inst  output  32  instruction register.
REQ-014 inst_pc  output  32  address of inst.
REQ-015 opcode / funct3 / funct7  output  7/3/7  SHALL be inst[6:0], inst[14:12], inst[31:25], combinational from the instruction register.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, DROP and FULL; one outstanding request maximum.
REQ-017 Outputs SHALL be registered except opcode/funct3/funct7; imem_req SHALL be 1 only in REQ; imem_addr SHALL equal pc register.
REQ-018 IDLE -> REQ unconditionally on first clock edge after rst deasserts.
REQ-019 REQ: imem_req & imem_ready -> WAIT; otherwise stay REQ with imem_addr stable.
REQ-020 WAIT: imem_rvalid -> capture inst <= imem_rdata, inst_pc <= pc, pc <= pc + 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), inst_valid <= 1, go FULL.
REQ-021 FULL: inst, inst_pc held stable while stall=1; stall=0 -> inst_valid <= 0, go REQ (consume occurs on the FULL cycle with stall=0).
REQ-022 DROP: wait for imem_rvalid, discard data (inst unchanged, inst_valid 0), go REQ.
REQ-023 imem_rvalid in IDLE, REQ or FULL SHALL be ignored.
REQ-024 redirect_valid SHALL have priority over all other transitions; pc <= {redirect_pc[31:2], 2'b00}.
REQ-025 Redirect in REQ without handshake -> stay REQ; with same-cycle handshake (stale request accepted) -> DROP.
REQ-026 Redirect in WAIT without rvalid -> DROP; with same-cycle rvalid -> discard data, go REQ.
REQ-027 Redirect in FULL -> inst_valid <= 0, go REQ, regardless of stall.
REQ-028 Redirect in DROP -> update pc, stay DROP; redirect in IDLE -> update pc, go REQ.
REQ-029 A discarded response SHALL never raise inst_valid or modify inst/inst_pc.
REQ-030 Minimum throughput: one instruction per 3 cycles (REQ, WAIT, FULL) with imem_ready=1, rvalid one cycle after accept, stall=0.

Reset
REQ-031 While rst=1: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=RESET_PC.
REQ-032 rst asserted mid-operation SHALL abandon any outstanding request; a response arriving after reset deassert SHALL be ignored unless state is WAIT from a new request.

Verification
REQ-033 Reset release, imem_ready=1, rvalid 1 cycle after accept, rdata=32'h0010_0093, stall=0 -> imem_addr 0 then 4; inst_valid=1 with inst_pc=0, opcode=7'b0010011, funct3=0.
REQ-034 stall=1 for 5 cycles in FULL -> inst/inst_pc/inst_valid unchanged, imem_req=0; release -> next request at pc+4.
REQ-035 Redirect to 32'h0000_0102 while in WAIT, stale rvalid next cycle with 32'hDEAD_BEEF -> data discarded, next imem_addr=32'h0000_0100, inst never equals 32'hDEAD_BEEF.
REQ-036 Redirect coincident with REQ handshake -> DROP; response discarded; reissue at redirect target.
REQ-037 RESET_PC=32'hFFFF_FFFC, one fetch -> second imem_addr=32'h0000_0000.
REQ-038 rst pulsed while in WAIT -> all outputs at reset values asynchronously; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, a single instruction
// register toward decode, and redirect handling that squashes in-flight responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP,
        S_FULL
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_inst;
    logic [31:0] w_inst_nxt;
    logic [31:0] r_inst_pc;
    logic [31:0] w_inst_pc_nxt;
    logic        r_inst_valid;
    logic        w_inst_valid_nxt;
    logic        r_imem_req;

    logic [31:0] w_redir_pc;
    logic [31:0] w_pc_inc;
    logic        w_hs;

    assign w_redir_pc = {redirect_pc[31:2], 2'b00};
    assign w_pc_inc   = r_pc + 32'd4;
    assign w_hs       = r_imem_req & imem_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_inst_nxt       = r_inst;
        w_inst_pc_nxt    = r_inst_pc;
        w_inst_valid_nxt = r_inst_valid;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
                if (redirect_valid) w_pc_nxt = w_redir_pc;
            end
            S_REQ: begin
                if (redirect_valid) begin
                    w_pc_nxt    = w_redir_pc;
                    // an accepted request now fetches a stale address
                    w_state_nxt = w_hs ? S_DROP : S_REQ;
                end else if (w_hs) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    w_inst_nxt       = imem_rdata;
                    w_inst_pc_nxt    = r_pc;
                    w_pc_nxt         = w_pc_inc;
                    w_inst_valid_nxt = 1'b1;
                    w_state_nxt      = S_FULL;
                end
            end
            S_DROP: begin
                if (redirect_valid) w_pc_nxt = w_redir_pc;
                // the stale response drains even if a further redirect lands with it,
                // otherwise DROP would wait for a response that never comes
                if (imem_rvalid) w_state_nxt = S_REQ;
            end
            S_FULL: begin
                if (redirect_valid) begin
                    w_pc_nxt         = w_redir_pc;
                    w_inst_valid_nxt = 1'b0;
                    w_state_nxt      = S_REQ;
                end else if (!stall) begin
                    w_inst_valid_nxt = 1'b0;
                    w_state_nxt      = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_inst       <= NOP;
            r_inst_pc    <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_imem_req   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_pc    <= w_inst_pc_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            // registered copy of "state is REQ" so imem_req is a flop output
            r_imem_req   <= (w_state_nxt == S_REQ);
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign opcode     = r_inst[6:0];
    assign funct3     = r_inst[14:12];
    assign funct7     = r_inst[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a random run checked against a
// transaction-level model (pc, outstanding request, held instruction).
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ready, imem_rvalid, redirect_valid, stall;
    logic [31:0] imem_rdata, redirect_pc;

    logic        imem_req, inst_valid;
    logic [31:0] imem_addr, inst, inst_pc;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;

    logic        b_req, b_valid;
    logic [31:0] b_addr, b_inst, b_inst_pc;
    logic [6:0]  b_opcode, b_funct7;
    logic [2:0]  b_funct3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .opcode(opcode), .funct3(funct3), .funct7(funct7)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(b_req), .imem_addr(b_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .inst_valid(b_valid), .inst(b_inst), .inst_pc(b_inst_pc),
        .opcode(b_opcode), .funct3(b_funct3), .funct7(b_funct7)
    );

    // transaction-level model of dut (RESET_PC = 0)
    bit          m_started, m_out, m_stale, m_full, m_acc;
    logic [31:0] m_pc, m_addr, m_inst, m_inst_pc;

    task automatic model_reset();
        m_started = 0; m_out = 0; m_stale = 0; m_full = 0; m_acc = 0;
        m_pc = 32'h0; m_addr = 32'h0; m_inst = NOP; m_inst_pc = 32'h0;
    endtask

    // Called at a negedge: drive inputs, take one rising edge, advance the model,
    // return at the following negedge.
    task automatic step(input bit rdy, input bit rv, input logic [31:0] rd,
                        input bit rdr, input logic [31:0] rpc, input bit st);
        bit req, resp;
        imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
        redirect_valid = rdr; redirect_pc = rpc; stall = st;
        @(posedge clk);
        req   = m_started && !m_out && !m_full;
        resp  = m_out && rv;
        m_acc = req && rdy;
        m_started = 1;
        if (m_full && (rdr || !st)) m_full = 0;
        if (resp) begin
            if (!(m_stale || rdr)) begin
                m_full = 1; m_inst = rd; m_inst_pc = m_addr; m_pc = m_addr + 32'd4;
            end
            m_out = 0;
        end
        if (m_acc) begin
            m_out = 1; m_addr = m_pc; m_stale = rdr;
        end else if (m_out && rdr) begin
            m_stale = 1;
        end
        if (rdr) m_pc = {rpc[31:2], 2'b00};
        @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1; imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
        redirect_valid = 0; redirect_pc = 0; stall = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; imem_ready = 1; imem_rvalid = 1; imem_rdata = 32'hFFFF_FFFF;
        redirect_valid = 1; redirect_pc = 32'h40; stall = 0;
        @(negedge clk);
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b exp=0", inst_valid); end
        n_cmp++; if (inst !== NOP) begin n_err++; $display("FAIL reset_inst got=%h exp=%h", inst, NOP); end
        n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL reset_inst_pc got=%h exp=0", inst_pc); end
        n_cmp++; if (b_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL reset_wrap_addr got=%h exp=fffffffc", b_addr); end
        reset_dut();
    endtask

    task automatic test_basic();
        reset_dut();
        step(0, 0, 0, 0, 0, 0);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL basic_req0 got=%0b/%h exp=1/0", imem_req, imem_addr); end
        n_cmp++; if (b_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_req0 got=%h exp=fffffffc", b_addr); end
        step(1, 0, 0, 0, 0, 0);
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL basic_wait_req got=%0b exp=0", imem_req); end
        step(1, 1, 32'h0010_0093, 0, 0, 0);
        n_cmp++; if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 32'h0) begin
            n_err++; $display("FAIL basic_full got=%0b/%h/%h exp=1/00100093/0", inst_valid, inst, inst_pc); end
        n_cmp++; if (opcode !== 7'b0010011 || funct3 !== 3'd0 || funct7 !== 7'd0) begin
            n_err++; $display("FAIL basic_decode got=%b/%0d/%0d exp=0010011/0/0", opcode, funct3, funct7); end
        n_cmp++; if (b_inst_pc !== 32'hFFFF_FFFC || b_addr !== 32'h0) begin
            n_err++; $display("FAIL wrap_pc got=%h/%h exp=fffffffc/0", b_inst_pc, b_addr); end
        step(1, 0, 0, 0, 0, 0);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || inst_valid !== 1'b0) begin
            n_err++; $display("FAIL basic_req1 got=%0b/%h/%0b exp=1/4/0", imem_req, imem_addr, inst_valid); end
        n_cmp++; if (b_req !== 1'b1 || b_addr !== 32'h0) begin n_err++; $display("FAIL wrap_req1 got=%0b/%h exp=1/0", b_req, b_addr); end
    endtask

    task automatic test_stall();
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 32'h0020_8113, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, i[0], 32'hBAD0_0000 + i, 0, 0, 1);
            n_cmp++; if (inst_valid !== 1'b1 || inst !== 32'h0020_8113 || inst_pc !== 32'h4 || imem_req !== 1'b0) begin
                n_err++; $display("FAIL stall_hold%0d got=%0b/%h/%h/%0b exp=1/00208113/4/0", i, inst_valid, inst, inst_pc, imem_req); end
        end
        step(1, 0, 0, 0, 0, 0);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_err++; $display("FAIL stall_release got=%0b/%h exp=1/8", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_wait();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h0000_0102, 0);
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rdw_drop_req got=%0b exp=0", imem_req); end
        step(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
            n_err++; $display("FAIL rdw_reissue got=%0b/%h/%0b exp=1/100/0", imem_req, imem_addr, inst_valid); end
        n_cmp++; if (inst === 32'hDEAD_BEEF) begin n_err++; $display("FAIL rdw_stale_inst got=%h exp!=deadbeef", inst); end
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 32'h0012_3456, 0, 0, 0);
        n_cmp++; if (inst !== 32'h0012_3456 || inst_pc !== 32'h100 || inst_valid !== 1'b1) begin
            n_err++; $display("FAIL rdw_fetch got=%h/%h/%0b exp=00123456/100/1", inst, inst_pc, inst_valid); end
        step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_redirect_hs();
        step(1, 0, 0, 1, 32'h0000_0203, 0);
        n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h200) begin
            n_err++; $display("FAIL rdh_drop got=%0b/%h exp=0/200", imem_req, imem_addr); end
        step(0, 1, 32'hCAFE_F00D, 0, 0, 0);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || inst_valid !== 1'b0 || inst === 32'hCAFE_F00D) begin
            n_err++; $display("FAIL rdh_reissue got=%0b/%h/%0b/%h exp=1/200/0/!=cafef00d", imem_req, imem_addr, inst_valid, inst); end
    endtask

    task automatic test_async_reset();
        step(1, 0, 0, 0, 0, 0);
        rst = 1;
        #1;
        n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst_valid !== 1'b0 || inst !== NOP || inst_pc !== 32'h0) begin
            n_err++; $display("FAIL async_rst got=%0b/%h/%0b/%h/%h exp=0/0/0/00000013/0", imem_req, imem_addr, inst_valid, inst, inst_pc); end
        @(negedge clk);
        rst = 0;
        model_reset();
        step(0, 1, 32'hBADC_0DE5, 0, 0, 0);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
            n_err++; $display("FAIL async_restart got=%0b/%h/%0b exp=1/0/0", imem_req, imem_addr, inst_valid); end
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 32'h0030_0193, 0, 0, 0);
        n_cmp++; if (inst !== 32'h0030_0193 || inst_pc !== 32'h0) begin
            n_err++; $display("FAIL async_fetch got=%h/%h exp=00300193/0", inst, inst_pc); end
    endtask

    task automatic test_random();
        int  dly = 0;
        bit  rv, exp_req;
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            rv = m_out ? (dly == 0) : ($urandom_range(0, 7) == 0);
            step($urandom_range(0, 3) != 0, rv, $urandom, $urandom_range(0, 9) == 0,
                 $urandom, $urandom_range(0, 2) == 0);
            if (m_acc) dly = $urandom_range(0, 2);
            else if (m_out && dly > 0) dly--;
            exp_req = m_started && !m_out && !m_full;
            n_cmp++; if (imem_req !== exp_req || imem_addr !== m_pc) begin
                n_err++; $display("FAIL rnd_req c=%0d got=%0b/%h exp=%0b/%h", c, imem_req, imem_addr, exp_req, m_pc); end
            n_cmp++; if (inst_valid !== m_full || inst !== m_inst || inst_pc !== m_inst_pc) begin
                n_err++; $display("FAIL rnd_inst c=%0d got=%0b/%h/%h exp=%0b/%h/%h", c, inst_valid, inst, inst_pc, m_full, m_inst, m_inst_pc); end
            n_cmp++; if (opcode !== m_inst[6:0] || funct3 !== m_inst[14:12] || funct7 !== m_inst[31:25]) begin
                n_err++; $display("FAIL rnd_decode c=%0d got=%h/%h/%h", c, opcode, funct3, funct7); end
        end
    endtask

    initial begin
        rst = 1; imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
        redirect_valid = 0; redirect_pc = 0; stall = 0;
        model_reset();
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_hs();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
